// File: rtl/servant_sleep_ctrl.sv
// servant_sleep_ctrl: gates the CPU/bus clock on sleep and
// re-enables it on a masked wake event after a settle delay.
module servant_sleep_ctrl #(
  parameter int NUM_WAKE   = 2,
  parameter int WAKE_DELAY = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_sleep_req,
  input  logic                i_wakeup_req,
  input  logic [NUM_WAKE-1:0] i_wake_src,
  input  logic [NUM_WAKE-1:0] i_wake_mask,
  input  logic                i_bus_idle,
  input  logic                i_cause_clr,
  output logic                o_clk_en,
  output logic                o_sleeping,
  output logic [NUM_WAKE:0]   o_wake_cause
);

  localparam int CW =
    (WAKE_DELAY > 0) ? $clog2(WAKE_DELAY + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'((WAKE_DELAY > 0) ? WAKE_DELAY - 1 : 0);
  localparam bit NO_DELAY = (WAKE_DELAY == 0);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    SLEEP = 2'd2,
    WAKE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [NUM_WAKE:0]   cause_q, cause_d;
  logic [NUM_WAKE-1:0] src_hit;
  logic [NUM_WAKE:0]   cause_vec;
  logic                wake_evt;
  logic                record;

  assign src_hit   = i_wake_src & i_wake_mask;
  assign wake_evt  = i_wakeup_req | (|src_hit);
  assign cause_vec = {src_hit, i_wakeup_req};

  // State, settle counter and sticky cause registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // Next state, counter load/decrement and cause recording.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    record  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (i_sleep_req) begin
          if (wake_evt) begin
            record = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (wake_evt) begin
          record  = 1'b1;
          state_d = RUN;
        end else if (i_bus_idle) begin
          state_d = SLEEP;
        end
      end
      SLEEP: begin
        if (wake_evt) begin
          record = 1'b1;
          if (NO_DELAY) begin
            state_d = RUN;
          end else begin
            state_d = WAKE;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAKE: begin
        record = wake_evt;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = RUN;
    endcase
    cause_d = (i_cause_clr ? '0 : cause_q)
            | (record ? cause_vec : '0);
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    o_clk_en     = (state_q == RUN) || (state_q == DRAIN);
    o_sleeping   = (state_q == SLEEP) || (state_q == WAKE);
    o_wake_cause = cause_q;
  end

endmodule

// File: tb/tb_servant_sleep_ctrl.sv
// tb_servant_sleep_ctrl: directed checks of sleep entry, drain,
// masked wake, cancel, cause clear and reset for delays 4, 8, 0.
module tb_servant_sleep_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sleep_req;
  logic       wakeup_req;
  logic [1:0] wake_src;
  logic [1:0] wake_mask;
  logic       bus_idle;
  logic       cause_clr;

  logic       en4, en8, en0;
  logic       slp4, slp8, slp0;
  logic [2:0] cz4, cz8, cz0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  servant_sleep_ctrl #(.NUM_WAKE(2), .WAKE_DELAY(4)) u_d4 (
    .i_clk(clk), .i_rst(rst),
    .i_sleep_req(sleep_req), .i_wakeup_req(wakeup_req),
    .i_wake_src(wake_src), .i_wake_mask(wake_mask),
    .i_bus_idle(bus_idle), .i_cause_clr(cause_clr),
    .o_clk_en(en4), .o_sleeping(slp4), .o_wake_cause(cz4)
  );

  servant_sleep_ctrl #(.NUM_WAKE(2), .WAKE_DELAY(8)) u_d8 (
    .i_clk(clk), .i_rst(rst),
    .i_sleep_req(sleep_req), .i_wakeup_req(wakeup_req),
    .i_wake_src(wake_src), .i_wake_mask(wake_mask),
    .i_bus_idle(bus_idle), .i_cause_clr(cause_clr),
    .o_clk_en(en8), .o_sleeping(slp8), .o_wake_cause(cz8)
  );

  servant_sleep_ctrl #(.NUM_WAKE(2), .WAKE_DELAY(0)) u_d0 (
    .i_clk(clk), .i_rst(rst),
    .i_sleep_req(sleep_req), .i_wakeup_req(wakeup_req),
    .i_wake_src(wake_src), .i_wake_mask(wake_mask),
    .i_bus_idle(bus_idle), .i_cause_clr(cause_clr),
    .o_clk_en(en0), .o_sleeping(slp0), .o_wake_cause(cz0)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic enter_sleep();
    sleep_req = 1'b1;
    bus_idle  = 1'b1;
    tick();
    sleep_req = 1'b0;
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    sleep_req  = 1'b0;
    wakeup_req = 1'b0;
    wake_src   = 2'b00;
    wake_mask  = 2'b11;
    bus_idle   = 1'b1;
    cause_clr  = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rst_clk_en", en4, 1);
      chk("rst_sleeping", slp4, 0);
      chk("rst_cause", cz4, 0);
    end

    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    chk("entry_n1_en", en4, 1);
    tick();
    chk("entry_n2_en", en4, 0);
    chk("entry_n2_slp", slp4, 1);
    tick();
    chk("sleep_hold", en4, 0);
    wakeup_req = 1'b1;
    tick();
    wakeup_req = 1'b0;
    chk("wk_m1_cause", cz4, 3'b001);
    chk("wk_m1_slp", slp4, 1);
    chk("d0_m1_en", en0, 1);
    chk("d0_m1_slp", slp0, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk("wk_count_en", en4, 0);
    end
    tick();
    chk("wk_m5_en", en4, 1);
    chk("wk_m5_slp", slp4, 0);
    chk("d8_m5_en", en8, 0);
    cause_clr = 1'b1;
    tick();
    cause_clr = 1'b0;
    chk("cause_clr", cz4, 0);

    do_reset();
    bus_idle  = 1'b0;
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("drain_en", en4, 1);
      tick();
    end
    chk("drain_end_en", en4, 1);
    bus_idle = 1'b1;
    tick();
    chk("drain_idle_en", en4, 0);

    do_reset();
    wake_mask = 2'b01;
    enter_sleep();
    chk("mask_sleep_en", en4, 0);
    wake_src = 2'b10;
    tick();
    chk("masked_en", en4, 0);
    chk("masked_cause", cz4, 0);
    tick();
    chk("masked_slp", slp4, 1);
    wake_src = 2'b11;
    tick();
    chk("src0_cause", cz4, 3'b010);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("src0_count_en", en4, 0);
    end
    tick();
    chk("src0_wake_en", en4, 1);
    sleep_req = 1'b1;
    tick();
    sleep_req = 1'b0;
    chk("level_cancel_en", en4, 1);
    tick();
    chk("level_cancel_en2", en4, 1);
    wake_src = 2'b00;

    do_reset();
    wake_mask  = 2'b11;
    sleep_req  = 1'b1;
    wakeup_req = 1'b1;
    tick();
    sleep_req  = 1'b0;
    wakeup_req = 1'b0;
    chk("cancel_en", en4, 1);
    chk("cancel_cause", cz4, 3'b001);
    tick();
    chk("cancel_en2", en4, 1);
    chk("cancel_slp2", slp4, 0);
    cause_clr = 1'b1;
    sleep_req = 1'b1;
    wake_src  = 2'b01;
    tick();
    cause_clr = 1'b0;
    sleep_req = 1'b0;
    wake_src  = 2'b00;
    chk("set_wins_clr", cz4, 3'b010);

    do_reset();
    enter_sleep();
    chk("d8_sleep_en", en8, 0);
    wakeup_req = 1'b1;
    tick();
    wakeup_req = 1'b0;
    chk("d0_evt_en", en0, 1);
    chk("d0_evt_cause", cz0, 3'b001);
    tick();
    tick();
    chk("d8_mid_slp", slp8, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("d8_rst_en", en8, 1);
    chk("d8_rst_slp", slp8, 0);
    chk("d8_rst_cause", cz8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
